spi_master: RTL and testbench

//  SPI master/initiator for the existing LSB-first SPI slave; generates Sclk, Cs, Mosi from one system clock.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_clk_gen.sv | 29 ++
 rtl/spi_master.sv | 98 +++++++++
 tb/tb_spi_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, idle levels and default word width for the SPI master
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE = 1'b1;
    localparam int LENGTH_DEF = 8;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer that produces the registered Sclk level and one-cycle edge strobes
module spi_clk_gen import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_tog,
    output logic o_tick,
    output logic o_rise_stb,
    output logic o_fall_stb,
    output logic o_sclk
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise_stb = o_tick && i_tog && !o_sclk;
    assign o_fall_stb = o_tick && i_tog && o_sclk;
    // half-period counter wraps on every timeout; Sclk toggles only when the FSM allows it
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
            o_sclk <= SCLK_IDLE;
        end else begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
            if (o_tick && i_tog) o_sclk <= !o_sclk;
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: LSB-first full-duplex SPI initiator (define SPI_MASTER_LOOPBACK_EN to sample Mosi instead of Miso)
module spi_master import spi_pkg::*; #(
    parameter int length = LENGTH_DEF,
    parameter int bits = 4,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [length-1:0] tx_data,
    input  logic              Miso,
    output logic              Sclk,
    output logic              Cs,
    output logic              Mosi,
    output logic [length-1:0] rx_data,
    output logic              busy,
    output logic              done
);
    localparam logic [bits-1:0] LAST = bits'(length + 1);
    state_t r_state, w_next;
    logic [length-1:0] r_tx, r_rx;
    logic [bits-1:0] r_cyc;
    logic w_tick, w_rise, w_fall, w_tog, w_accept, w_finish, w_sdi;
`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_sdi = Mosi;
`else
    assign w_sdi = Miso;
`endif
    // once all length+1 rises are done, the next timeout ends XFER instead of raising Sclk
    assign w_tog = (r_state == SETUP) || (r_state == XFER && (Sclk || r_cyc != LAST));
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_state != IDLE),
        .i_tog      (w_tog),
        .o_tick     (w_tick),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall),
        .o_sclk     (Sclk)
    );
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next-state logic with accept/finish events for the datapath
    always_comb begin
        w_next = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = start;
                w_next = start ? SETUP : IDLE;
            end
            SETUP: w_next = w_tick ? XFER : SETUP;
            XFER: w_next = (w_tick && !w_tog) ? HOLD : XFER;
            HOLD: begin
                w_finish = w_tick;
                w_next = w_tick ? IDLE : HOLD;
            end
        endcase
    end
    // shift registers, rise counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            Cs <= CS_IDLE;
            Mosi <= 1'b0;
            rx_data <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            r_tx <= '0;
            r_rx <= '0;
            r_cyc <= '0;
        end else begin
            done <= w_finish;
            if (w_accept) begin
                r_tx <= tx_data;
                Cs <= 1'b0;
                busy <= 1'b1;
            end
            if (w_finish) begin
                Cs <= CS_IDLE;
                busy <= 1'b0;
                rx_data <= r_rx;
            end
            if (w_fall) begin
                Mosi <= r_tx[0];
                r_tx <= r_tx >> 1;
            end
            if (w_rise) begin
                if (r_cyc != '0) r_rx <= {w_sdi, r_rx[length-1:1]};
                if (r_cyc != LAST) r_cyc <= r_cyc + 1'b1;
            end
            if (r_state == IDLE) r_cyc <= '0;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of framing, latency, abort, back-to-back frames and bus timing
module tb_spi_master;
    logic clk, rst, start, Miso, Sclk, Cs, Mosi, busy, done;
    logic [7:0] tx_data, rx_data, slv_din, slv_rec;
    logic loop, slv_miso, p_sclk, p_cs, p_mosi, p_rst;
    int cyc, n_chk, n_pass, rises, falls, mosi_bad, cs_bad;
    int lat, gaps, nd;

    spi_master dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .Miso    (Miso),
        .Sclk    (Sclk),
        .Cs      (Cs),
        .Mosi    (Mosi),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LSB-first slave model: bit k driven after fall k+1, zero after the word is exhausted
    assign slv_miso = (falls >= 1 && falls <= 8) ? slv_din[3'(falls - 1)] : 1'b0;
    assign Miso = loop ? Mosi : slv_miso;

    initial begin
        rises = 0; falls = 0; mosi_bad = 0; cs_bad = 0; slv_rec = 0;
    end
    // edge monitor: compares values just before and just after each clk edge
    always @(posedge clk) begin
        p_sclk = Sclk; p_cs = Cs; p_mosi = Mosi; p_rst = rst;
        #1;
        if (!p_rst) begin
            if (p_cs && !Cs) begin rises = 0; falls = 0; end
            if (!p_sclk && Sclk && !Cs) begin
                rises++;
                slv_rec = {Mosi, slv_rec[7:1]};
                if (Mosi !== p_mosi) mosi_bad++;
            end
            if (p_sclk && !Sclk && !Cs) falls++;
            if (Cs !== p_cs && (p_sclk || Sclk)) cs_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic kick(input logic [7:0] tx);
        start = 1; tx_data = tx;
        @(negedge clk);
        start = 0; tx_data = ~tx;
    endtask

    task automatic wait_done(input int poke, output int l, output int g);
        int t0;
        t0 = cyc; l = -1; g = 0;
        for (int i = 0; i < 200 && l < 0; i++) begin
            if (done) l = cyc - t0;
            else begin
                if (!busy) g++;
                if (i == poke) begin start = 1; tx_data = 8'hFF; end
                else if (i == poke + 1) start = 0;
                @(negedge clk);
            end
        end
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) c++;
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1; start = 0; tx_data = 0; loop = 1; slv_din = 0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(Sclk), 0);
        chk("rst_cs", 32'(Cs), 1);
        chk("rst_mosi", 32'(Mosi), 0);
        chk("rst_rx", 32'(rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 0;
        @(negedge clk);
        // abort: reset 30 cycles into a frame
        kick(8'hFF);
        repeat (29) @(negedge clk);
        chk("abort_pre_sclk", 32'(Sclk), 1);
        chk("abort_pre_mosi", 32'(Mosi), 1);
        chk("abort_pre_cs", 32'(Cs), 0);
        chk("abort_pre_busy", 32'(busy), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_cs", 32'(Cs), 1);
        chk("abort_sclk", 32'(Sclk), 0);
        chk("abort_mosi", 32'(Mosi), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rx", 32'(rx_data), 0);
        count_done(100, nd);
        chk("abort_no_done", 32'(nd), 0);
        // loopback frame A5
        kick(8'hA5);
        wait_done(1000, lat, gaps);
        chk("a5_latency", 32'(lat), 80);
        chk("a5_busy_gaps", 32'(gaps), 0);
        chk("a5_rx", 32'(rx_data), 32'h A5);
        chk("a5_rises", 32'(rises), 9);
        @(negedge clk);
        chk("a5_done_pulse", 32'(done), 0);
        chk("a5_cs_idle", 32'(Cs), 1);
        // slave frame: master sends 3C, slave returns C3
        loop = 0; slv_din = 8'hC3;
        repeat (2) @(negedge clk);
        kick(8'h3C);
        wait_done(1000, lat, gaps);
        chk("slv_latency", 32'(lat), 80);
        chk("slv_master_rx", 32'(rx_data), 32'h C3);
        chk("slv_rec", 32'(slv_rec), 32'h 3C);
        loop = 1;
        repeat (2) @(negedge clk);
        // start repeated 10 cycles into a frame must be ignored
        kick(8'h5A);
        wait_done(10, lat, gaps);
        chk("ign_latency", 32'(lat), 80);
        chk("ign_busy_gaps", 32'(gaps), 0);
        chk("ign_rx", 32'(rx_data), 32'h 5A);
        count_done(100, nd);
        chk("ign_extra_done", 32'(nd), 0);
        chk("ign_idle_busy", 32'(busy), 0);
        // start held high: two frames back-to-back
        kick(8'h01);
        start = 1; tx_data = 8'h80;
        wait_done(1000, lat, gaps);
        chk("b2b1_latency", 32'(lat), 80);
        chk("b2b1_rx", 32'(rx_data), 32'h 01);
        chk("b2b_cs_gap_high", 32'(Cs), 1);
        @(negedge clk);
        start = 0;
        chk("b2b_cs_gap_low", 32'(Cs), 0);
        chk("b2b2_busy", 32'(busy), 1);
        wait_done(1000, lat, gaps);
        chk("b2b2_latency", 32'(lat), 80);
        chk("b2b2_rx", 32'(rx_data), 32'h 80);
        chk("b2b2_rises", 32'(rises), 9);
        repeat (3) @(negedge clk);
        chk("mosi_stable_at_rise", 32'(mosi_bad), 0);
        chk("cs_toggle_sclk_high", 32'(cs_bad), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
